// File: rtl/aska_spi_regfile.sv
// SPI Mode 0 frame decoder feeding a bank of 2**AW config registers.
// Define ASKA_REGFILE_READBACK_EN to build the MISO readback path.
module aska_spi_regfile #(
   parameter int DW = 32,
   parameter int AW = 2,
   parameter int HW = 8
) (
   input  logic                  resetn,
   input  logic                  SPI_Clk,
   input  logic                  SPI_CS,
   input  logic                  SPI_MOSI,
   output logic                  SPI_MISO,
   output logic [(2**AW)*DW-1:0] regs_q,
   output logic [2**AW-1:0]      wr_tgl,
   output logic                  frame_err
);
   localparam int NR = 2**AW;
   localparam int FL = HW + DW;
   localparam logic [5:0] C_HDR  = 6'(HW - 1);
   localparam logic [5:0] C_LAST = 6'(FL - 1);
   localparam logic [5:0] C_END  = 6'(FL);

   logic [5:0]    r_cnt;
   logic [DW-2:0] r_sh;
   logic [HW-1:0] r_hdr;
   logic [DW-1:0] r_regs [NR];
   logic [HW-1:0] w_hdr_now;
   logic          w_rsv_bad;
   logic [AW-1:0] w_addr;
   logic          w_last;

   assign w_hdr_now = {r_sh[HW-2:0], SPI_MOSI};
   assign w_rsv_bad = |r_hdr[HW-2:AW];
   assign w_addr    = r_hdr[AW-1:0];
   assign w_last    = (r_cnt == C_LAST);

   // Frame state is cleared asynchronously whenever CS is released.
   always_ff @(posedge SPI_Clk or negedge resetn or posedge SPI_CS) begin
      if (!resetn) begin
         r_cnt <= '0;
         r_sh  <= '0;
         r_hdr <= '0;
      end else if (SPI_CS) begin
         r_cnt <= '0;
         r_sh  <= '0;
         r_hdr <= '0;
      end else if (r_cnt != C_END) begin
         r_cnt <= r_cnt + 6'd1;
         r_sh  <= {r_sh[DW-3:0], SPI_MOSI};
         if (r_cnt == C_HDR)
            r_hdr <= w_hdr_now;
      end
   end

   always_ff @(posedge SPI_Clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NR; i++)
            r_regs[i] <= '0;
         wr_tgl    <= '0;
         frame_err <= 1'b0;
      end else if (w_last) begin
         if (w_rsv_bad) begin
            frame_err <= 1'b1;
         end else begin
            frame_err <= 1'b0;
            if (r_hdr[HW-1]) begin
               r_regs[w_addr] <= {r_sh, SPI_MOSI};
               wr_tgl[w_addr] <= ~wr_tgl[w_addr];
            end
         end
      end
   end

   always_comb begin
      regs_q = '0;
      for (int i = 0; i < NR; i++)
         regs_q[i*DW +: DW] = r_regs[i];
   end

`ifdef ASKA_REGFILE_READBACK_EN
   logic [DW-1:0] r_tx;
   logic          w_dat;

   assign w_dat = (r_cnt >= 6'(HW)) && (r_cnt != C_END);

   // Write frames and bad headers load zero, so MISO stays low for them.
   always_ff @(posedge SPI_Clk or negedge resetn or posedge SPI_CS) begin
      if (!resetn) begin
         r_tx <= '0;
      end else if (SPI_CS) begin
         r_tx <= '0;
      end else if (r_cnt == C_HDR) begin
         if (!w_hdr_now[HW-1] && !(|w_hdr_now[HW-2:AW]))
            r_tx <= r_regs[w_hdr_now[AW-1:0]];
         else
            r_tx <= '0;
      end else if (w_dat) begin
         r_tx <= {r_tx[DW-2:0], 1'b0};
      end
   end

   always_ff @(negedge SPI_Clk or negedge resetn or posedge SPI_CS) begin
      if (!resetn)
         SPI_MISO <= 1'b0;
      else if (SPI_CS)
         SPI_MISO <= 1'b0;
      else
         SPI_MISO <= w_dat & r_tx[DW-1];
   end
`else
   assign SPI_MISO = 1'b0;
`endif

endmodule

// File: tb/tb_aska_spi_regfile.sv
// Directed bench for aska_spi_regfile with a frame-level register model
// compared against the DUT outputs once per SPI clock.
module tb_aska_spi_regfile;
`ifdef ASKA_REGFILE_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic         resetn;
   logic         SPI_Clk;
   logic         SPI_CS;
   logic         SPI_MOSI;
   logic         SPI_MISO;
   logic [127:0] regs_q;
   logic [3:0]   wr_tgl;
   logic         frame_err;

   logic [31:0] mreg [4];
   logic [3:0]  mtgl;
   logic        merr;
   logic        exp_miso;
   logic        cap;
   logic        cmp_en;
   logic [31:0] rx;
   int          checks;
   int          errors;

   aska_spi_regfile dut (
      .resetn   (resetn),
      .SPI_Clk  (SPI_Clk),
      .SPI_CS   (SPI_CS),
      .SPI_MOSI (SPI_MOSI),
      .SPI_MISO (SPI_MISO),
      .regs_q   (regs_q),
      .wr_tgl   (wr_tgl),
      .frame_err(frame_err)
   );

   initial SPI_Clk = 1'b0;
   always #5 SPI_Clk = ~SPI_Clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < 4; n++)
         mreg[n] = '0;
      mtgl = '0;
      merr = 1'b0;
   endtask

   always @(negedge SPI_Clk) begin
      #4;
      if (cmp_en) begin
         for (int n = 0; n < 4; n++)
            chk($sformatf("regs_q[%0d]", n), regs_q[n*32 +: 32], mreg[n]);
         chk("wr_tgl", {28'b0, wr_tgl}, {28'b0, mtgl});
         chk("frame_err", {31'b0, frame_err}, {31'b0, merr});
         chk("SPI_MISO", {31'b0, SPI_MISO}, {31'b0, exp_miso});
         if (cap)
            rx = {rx[30:0], SPI_MISO};
      end
   end

   task automatic frame(input logic [7:0] h, input logic [31:0] d,
                        input int nbits);
      logic [39:0] f;
      logic [31:0] rd;
      bit          rd_ok;
      f     = {h, d};
      rd_ok = !h[7] && (h[6:2] == 5'd0);
      rd    = mreg[h[1:0]];
      for (int i = 0; i < nbits; i++) begin
         @(negedge SPI_Clk);
         SPI_CS   = 1'b0;
         SPI_MOSI = (i < 40) ? f[39-i] : 1'b0;
         cap      = (i >= 8) && (i <= 39);
         exp_miso = RB && rd_ok && cap && rd[39-i];
         @(posedge SPI_Clk);
         #1;
         if (i == 39) begin
            if (h[6:2] != 5'd0) begin
               merr = 1'b1;
            end else begin
               merr = 1'b0;
               if (h[7]) begin
                  mreg[h[1:0]] = d;
                  mtgl[h[1:0]] = ~mtgl[h[1:0]];
               end
            end
         end
      end
      @(negedge SPI_Clk);
      SPI_CS   = 1'b1;
      SPI_MOSI = 1'b0;
      cap      = 1'b0;
      exp_miso = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      cmp_en   = 1'b0;
      cap      = 1'b0;
      exp_miso = 1'b0;
      rx       = '0;
      resetn   = 1'b0;
      SPI_CS   = 1'b1;
      SPI_MOSI = 1'b0;
      model_reset();
      #23;
      chk("rst regs_lo", regs_q[31:0] | regs_q[63:32], 32'h0);
      chk("rst regs_hi", regs_q[95:64] | regs_q[127:96], 32'h0);
      chk("rst tgl_err_miso", {27'b0, wr_tgl, frame_err, SPI_MISO}, 32'h0);
      resetn = 1'b1;
      cmp_en = 1'b1;

      frame(8'h82, 32'hDEADBEEF, 40);
      chk("w2 reg2", regs_q[64 +: 32], 32'hDEADBEEF);
      chk("w2 tgl", {28'b0, wr_tgl}, 32'h4);
      chk("w2 others", regs_q[31:0] | regs_q[63:32] | regs_q[127:96], 32'h0);

      frame(8'h81, 32'h12345678, 40);
      rx = '0;
      frame(8'h01, 32'hCAFEF00D, 40);
      chk("rd1 data", rx, RB ? 32'h12345678 : 32'h0);
      chk("rd1 reg1", regs_q[32 +: 32], 32'h12345678);
      rx = '0;
      frame(8'h02, 32'h0, 40);
      chk("rd2 data", rx, RB ? 32'hDEADBEEF : 32'h0);

      frame(8'h84, 32'hFFFFFFFF, 40);
      chk("bad err", {31'b0, frame_err}, 32'h1);
      chk("bad tgl", {28'b0, wr_tgl}, 32'h6);
      frame(8'h80, 32'h00000001, 40);
      chk("w0 reg0", regs_q[31:0], 32'h1);
      chk("w0 err", {31'b0, frame_err}, 32'h0);
      rx = '1;
      frame(8'h04, 32'h0, 40);
      chk("badrd err", {31'b0, frame_err}, 32'h1);
      chk("badrd data", rx, 32'h0);

      frame(8'h83, 32'hAAAAAAAA, 20);
      chk("abort reg3", regs_q[96 +: 32], 32'h0);
      chk("abort tgl", {28'b0, wr_tgl}, 32'h7);
      frame(8'h83, 32'hAAAAAAAA, 40);
      chk("w3 reg3", regs_q[96 +: 32], 32'hAAAAAAAA);
      chk("w3 tgl", {28'b0, wr_tgl}, 32'hF);

      frame(8'h80, 32'h0000FFFF, 48);
      chk("long reg0", regs_q[31:0], 32'h0000FFFF);
      chk("long tgl", {28'b0, wr_tgl}, 32'hE);

      @(negedge SPI_Clk);
      SPI_CS = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge SPI_Clk);
         SPI_MOSI = 1'($urandom_range(0, 1));
      end
      #1;
      resetn = 1'b0;
      model_reset();
      #1;
      chk("mrst regs_lo", regs_q[31:0] | regs_q[63:32], 32'h0);
      chk("mrst regs_hi", regs_q[95:64] | regs_q[127:96], 32'h0);
      chk("mrst tgl_err_miso", {27'b0, wr_tgl, frame_err, SPI_MISO}, 32'h0);
      repeat (2) @(negedge SPI_Clk);
      SPI_CS = 1'b1;
      #2;
      resetn = 1'b1;
      frame(8'h81, 32'h0BADF00D, 40);
      chk("post reg1", regs_q[32 +: 32], 32'h0BADF00D);
      chk("post tgl", {28'b0, wr_tgl}, 32'h2);

      repeat (2) @(negedge SPI_Clk);
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
